// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: debounced button steps through four LED patterns,
// each advanced by a prescaled step tick and dimmed by a 16-phase PWM.
module led_pattern_sequencer #(
    parameter int STEP_DIV  = 1200000,
    parameter int DB_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn,
    input  logic [3:0] bright,
    output logic [7:0] leds,
    output logic [1:0] mode
);

    localparam int PW = $clog2(STEP_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        M_ALL_ON = 2'd0,
        M_SCAN   = 2'd1,
        M_COUNT  = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    logic          sync1, sync2;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          press;
    logic [PW-1:0] presc;
    logic          step;
    logic [3:0]    pwm_cnt;
    logic          lit;

    mode_t      mode_q, mode_d;
    logic [7:0] pattern_q, pattern_d;
    logic       dir_up_q, dir_up_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press fires in the same cycle the debounced level is about to rise.
    assign press = sync2 & ~db_level & (db_cnt == DB_MAX);
    assign step  = (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (press || step) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q    <= M_ALL_ON;
            pattern_q <= 8'hFF;
            dir_up_q  <= 1'b1;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            dir_up_q  <= dir_up_d;
        end
    end

    // A press takes priority over a coincident step tick.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        dir_up_d  = dir_up_q;
        if (press) begin
            dir_up_d = 1'b1;
            unique case (mode_q)
                M_ALL_ON: begin mode_d = M_SCAN;   pattern_d = 8'h01; end
                M_SCAN:   begin mode_d = M_COUNT;  pattern_d = 8'h00; end
                M_COUNT:  begin mode_d = M_BLINK;  pattern_d = 8'hFF; end
                M_BLINK:  begin mode_d = M_ALL_ON; pattern_d = 8'hFF; end
            endcase
        end else if (step) begin
            unique case (mode_q)
                M_SCAN: begin
                    if (dir_up_q) begin
                        pattern_d = {pattern_q[6:0], 1'b0};
                        if (pattern_q[6]) dir_up_d = 1'b0;
                    end else begin
                        pattern_d = {1'b0, pattern_q[7:1]};
                        if (pattern_q[1]) dir_up_d = 1'b1;
                    end
                end
                M_COUNT:  pattern_d = pattern_q + 8'd1;
                M_BLINK:  pattern_d = ~pattern_q;
                M_ALL_ON: pattern_d = pattern_q;
            endcase
        end
    end

    assign lit = (pwm_cnt <= bright);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt <= 4'd0;
            leds    <= 8'h00;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            leds    <= pattern_q & {8{lit}};
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: a fast-parameter instance for the pattern
// and PWM scenarios plus a default-step instance for the mid-scan reset.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rstn, rstn_b;
    logic       btn, btn_b;
    logic [3:0] bright;
    logic [7:0] leds, leds_b;
    logic [1:0] mode, mode_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] bright;
        int         on_cnt;
    } pwm_vec_t;

    pwm_vec_t   pwm_tab[5];
    logic [7:0] scan_exp[16];

    led_pattern_sequencer #(.STEP_DIV(4), .DB_CYCLES(3)) u_dut (
        .clk(clk), .rstn(rstn), .btn(btn), .bright(bright),
        .leds(leds), .mode(mode)
    );

    led_pattern_sequencer #(.DB_CYCLES(3)) u_big (
        .clk(clk), .rstn(rstn_b), .btn(btn_b), .bright(bright),
        .leds(leds_b), .mode(mode_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string name, input logic [7:0] act);
        logic [7:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %0h with no expected value queued", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", name, act, e);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mode_change(output int lat);
        logic [1:0] old;
        old = mode;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mode == old && lat < 20);
    endtask

    // driver: raise btn at a negedge and count cycles until mode moves
    task automatic press_dut(output int lat);
        btn = 1'b1;
        wait_mode_change(lat);
    endtask

    initial begin
        int lat, cnt, bad;

        pwm_tab[0] = '{4'd0,  1};
        pwm_tab[1] = '{4'd7,  8};
        pwm_tab[2] = '{4'd15, 16};
        pwm_tab[3] = '{4'd3,  4};
        pwm_tab[4] = '{4'd10, 11};
        scan_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        btn = 1'b0; btn_b = 1'b0; bright = 4'd15; rstn = 1'b0; rstn_b = 1'b0;
        wait_cycles(3);
        check("rst_leds", leds, 8'h00);
        check("rst_mode", mode, 2'd0);
        check("rst_leds_big", leds_b, 8'h00);
        rstn = 1'b1; rstn_b = 1'b1;
        wait_cycles(2);
        check("post_rst_leds", leds, 8'hFF);
        check("post_rst_mode", mode, 2'd0);

        // PWM duty table in ALL_ON
        foreach (pwm_tab[i]) begin
            bright = pwm_tab[i].bright;
            wait_cycles(2);
            cnt = 0; bad = 0;
            repeat (16) begin
                @(negedge clk);
                if (leds == 8'hFF) cnt++;
                else if (leds != 8'h00) bad++;
            end
            sb_push(8'(pwm_tab[i].on_cnt));
            sb_check($sformatf("pwm_on_b%0d", pwm_tab[i].bright), 8'(cnt));
            check("pwm_levels", bad, 0);
        end
        bright = 4'd15;

        // clean press into SCAN
        press_dut(lat);
        btn = 1'b0;
        check("press_latency", lat, 5);
        check("mode_scan", mode, 2'd1);
        foreach (scan_exp[i]) sb_push(scan_exp[i]);
        wait_cycles(2);
        for (int i = 0; i < 16; i++) begin
            sb_check($sformatf("scan_%0d", i), leds);
            if (i < 15) wait_cycles(4);
        end
        check("release_no_press", mode, 2'd1);
        wait_cycles(6);

        // bouncing button then settle high
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0);
            wait_cycles(2);
            if (mode != 2'd1) bad++;
        end
        check("bounce_no_advance", bad, 0);
        btn = 1'b1;
        wait_cycles(4);
        check("bounce_pre_edge", mode, 2'd1);
        wait_cycles(1);
        check("bounce_edge", mode, 2'd2);
        btn = 1'b0;

        // COUNT: 256 steps from 0x00 wraps back to 0x00
        for (int i = 0; i < 257; i++) sb_push(8'(i));
        wait_cycles(2);
        for (int i = 0; i < 257; i++) begin
            sb_check("count", leds);
            if (i < 256) wait_cycles(4);
        end
        // press timed so its cycle coincides with the step tick
        wait_cycles(1);
        press_dut(lat);
        btn = 1'b0;
        check("tick_press_latency", lat, 5);
        check("mode_blink", mode, 2'd3);
        wait_cycles(1);
        check("tick_press_no_count", leds, 8'hFF);
        sb_push(8'hFF); sb_push(8'h00); sb_push(8'hFF);
        wait_cycles(1);
        for (int i = 0; i < 3; i++) begin
            sb_check("blink", leds);
            if (i < 2) wait_cycles(4);
        end
        wait_cycles(6);
        press_dut(lat);
        btn = 1'b0;
        check("wrap_mode", mode, 2'd0);
        wait_cycles(2);
        check("wrap_leds", leds, 8'hFF);
        wait_cycles(8);

        // button held through reset release
        rstn = 1'b0;
        btn  = 1'b1;
        wait_cycles(3);
        check("held_rst_mode", mode, 2'd0);
        rstn = 1'b1;
        wait_mode_change(lat);
        check("held_latency", lat, 5);
        check("held_mode", mode, 2'd1);
        btn = 1'b0;

        // asynchronous reset mid-SCAN on the default-step instance
        btn_b = 1'b1;
        cnt = 0;
        while (mode_b != 2'd1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        btn_b = 1'b0;
        check("big_mode_scan", mode_b, 2'd1);
        wait_cycles(10);
        check("big_scan_leds", leds_b, 8'h01);
        #2;
        rstn_b = 1'b0;
        #1;
        check("big_async_leds", leds_b, 8'h00);
        check("big_async_mode", mode_b, 2'd0);
        check("big_async_presc", 32'(u_big.presc), 32'd0);
        @(negedge clk);
        rstn_b = 1'b1;
        check("big_release_presc", 32'(u_big.presc), 32'd0);
        wait_cycles(3);
        check("big_presc_restart", 32'(u_big.presc), 32'd3);
        check("big_release_mode", mode_b, 2'd0);

        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
